pipe_ctrl: RTL
==============

# pipe_ctrl

Central pipeline sequencer for the 5-stage MIPS datapath (IFM, I_Decode, Execute, MEMORY, WB). It drives the PC and pipeline-register write enables and flush/bubble strobes. It handles:
- post-reset pipeline clearing,
- load-use stalls,
- branch-taken squashes,
- data-memory wait freezes,
- a controlled drain-and-halt sequence with resume.

## Interface
Parameters:
- REG_AW, 5, register-address width
- INIT_CYCLES, 5, post-reset flush cycles (≥1)
- DRAIN_CYCLES, 4, advancing cycles needed to retire in-flight instructions
- CNT_W, 16, performance-counter width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_rs, id_rt  in  REG_AW  source registers of instruction in ID
- ex_memread  in  1  ID/EX instruction is a load
- ex_rt  in  REG_AW  load destination in ID/EX
- mem_pcsrc  in  1  branch taken, resolved in MEM (MEM_PCSrc)
- mem_busy  in  1  data memory not ready this cycle
- halt_req  in  1  single-cycle halt request
- resume  in  1  leave HALT
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1  stage write enables
- if_id_flush, id_ex_bubble, ex_mem_flush  out  1  load zero/NOP into the register when it writes
- halted  out  1  pipeline empty and stopped
- state  out  3  current FSM state (debug)
- cyc_cnt, stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- States: INIT, RUN, DRAIN, HALT. Only state, init/drain counter and perf counters are registered. All other outputs are combinational from state and inputs.
- Default in RUN: all writes 1, all flushes 0.
- Event priority (RUN and DRAIN): mem_busy > mem_pcsrc > load-use > halt_req.
- Freeze (mem_busy=1):
  - all five writes 0, all flushes 0.
  - Counters and FSM hold.
  - halt_req is ignored.
- Branch (mem_pcsrc=1):
  - pc_write=1, so the PC loads EX_MEM_NPC.
  - if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1: the three younger instructions are squashed in one cycle.
- Load-use is detected when all hold: id_valid, ex_memread, ex_rt≠0, and ex_rt equals id_rs or id_rt.
  - Response: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - The condition self-clears next cycle because the bubble sits in EX.
- INIT:
  - pc_write=0; other writes 1; if_id_flush=id_ex_bubble=ex_mem_flush=1.
  - Counter increments; after INIT_CYCLES cycles, go to RUN.
  - mem_busy is ignored.
- RUN → DRAIN on halt_req with no higher-priority event. The drain counter clears to 0.
- DRAIN:
  - pc_write=0, if_id_flush=1 (fetch stops; bubbles enter).
  - The counter increments only on advancing cycles (no freeze, no load-use stall).
  - After DRAIN_CYCLES advancing cycles, go to HALT.
  - A branch in DRAIN still flushes, with pc_write=1 so the target is kept for resume.
- HALT:
  - all writes 0, halted=1.
  - resume → INIT (PC is preserved; pipeline re-cleared).
- halt_req outside RUN is ignored.

## Timing
- Reset (async assert, sync release):
  - state=INIT, counters 0.
  - Outputs: pc_write=0, if_id_write=id_ex_write=ex_mem_write=mem_wb_write=1, all flushes 1, halted=0, perf counters 0.
- Stall and flush outputs have zero-cycle latency: they are valid in the same cycle as the input.
- The first fetch PC write happens in cycle INIT_CYCLES after reset release.
- halt_req at edge N: DRAIN starts at N+1, and halted rises DRAIN_CYCLES advancing cycles later.
- State transitions occur on the clk rising edge only.
- Reset asserted mid-DRAIN or mid-freeze returns to INIT immediately; the partial drain is discarded.
- Perf counters saturate at all-ones.
  - cyc_cnt: every cycle outside HALT.
  - stall_cnt: load-use plus freeze cycles.
  - flush_cnt: branch squashes.

## Configuration
- PIPE_CTRL_PERF_CNT_EN
  - Defined: the three saturating counters are implemented.
  - Undefined: the ports remain, tied to 0, and no counter flops are synthesised.

## Structure
- pipe_ctrl_pkg holds:
  - state enum (INIT=0, RUN=1, DRAIN=2, HALT=3),
  - REG_AW default,
  - priority/encoding constants.
- Sub-module pipe_hazard_det: combinational load-use comparator (id_valid, id_rs, id_rt, ex_memread, ex_rt → load_use). It is reusable by a later forwarding unit.

## Test plan
- Reset released:
  - Cycles 0–4: pc_write=0, all flushes=1, state=INIT.
  - Cycle 5: RUN, pc_write=1.
- RUN, ex_memread=1, ex_rt=8, id_rs=8, id_valid=1:
  - Same cycle: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - With ex_rt=0: no stall.
- mem_pcsrc=1 together with a load-use condition: branch wins (pc_write=1, all three flushes=1); flush_cnt increments by 1.
- mem_busy held 3 cycles during a branch: all writes 0 for 3 cycles, then the branch flush occurs on the 4th cycle.
- halt_req in RUN; load-use stall once in DRAIN:
  - halted asserts after 5 DRAIN cycles (4 advancing).
  - resume → INIT for 5 cycles → RUN.
- Reset asserted mid-DRAIN: immediate INIT, halted=0.
  - Also check: with PIPE_CTRL_PERF_CNT_EN undefined, cyc_cnt stays 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline sequencer
//
// Contents:
//   state_e     : sequencer state encoding (INIT=0, RUN=1, DRAIN=2, HALT=3)
//   REG_AW_DEF  : default register-address width
//   SEQ_W       : width of the shared INIT/DRAIN sequencing counter
//   OUT_*       : bit positions of the packed stage-control vector
//   sat_inc     : saturating increment used by the performance counters
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_HALT  = 3'd3
    } state_e;

    localparam int REG_AW_DEF = 5;

    // Covers INIT_CYCLES / DRAIN_CYCLES up to 255.
    localparam int SEQ_W = 8;

    // Packed control vector layout {pc, if_id, id_ex, ex_mem, mem_wb,
    // if_id_flush, id_ex_bubble, ex_mem_flush}.
    localparam int OUT_PC_W    = 7;
    localparam int OUT_IFID_W  = 6;
    localparam int OUT_IDEX_W  = 5;
    localparam int OUT_EXMEM_W = 4;
    localparam int OUT_MEMWB_W = 3;
    localparam int OUT_IFID_F  = 2;
    localparam int OUT_IDEX_B  = 1;
    localparam int OUT_EXMEM_F = 0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != '1)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/pipe_hazard_det.sv
// rtl/pipe_hazard_det.sv - combinational load-use hazard comparator
//
// Ports:
//   id_valid   in  IF/ID holds a real instruction
//   id_rs      in  source register rs of the instruction in ID
//   id_rt      in  source register rt of the instruction in ID
//   ex_memread in  ID/EX instruction is a load
//   ex_rt      in  load destination register in ID/EX
//   load_use   out ID instruction needs the load result before it exists
module pipe_hazard_det #(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rt,
    output logic              load_use
);

    // $zero never carries a dependency, so a load to r0 never stalls.
    assign load_use = id_valid && ex_memread && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage MIPS pipeline sequencer (stall/flush/drain/halt)
//
// Optional feature macro: PIPE_CTRL_PERF_CNT_EN (saturating perf counters;
// when undefined the counter ports are tied to zero).
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   id_valid, id_rs, id_rt        instruction in ID
//   ex_memread, ex_rt             load in EX
//   mem_pcsrc                     branch taken, resolved in MEM
//   mem_busy                      data memory not ready
//   halt_req, resume              drain-and-halt request / leave HALT
//   pc_write .. mem_wb_write      stage write enables
//   if_id_flush, id_ex_bubble,
//   ex_mem_flush                  squash strobes
//   halted                        pipeline empty and stopped
//   state                         current FSM state
//   cyc_cnt, stall_cnt, flush_cnt performance counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int INIT_CYCLES  = 5,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              mem_pcsrc,
    input  logic              mem_busy,
    input  logic              halt_req,
    input  logic              resume,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_write,
    output logic              ex_mem_write,
    output logic              mem_wb_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              ex_mem_flush,
    output logic              halted,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [SEQ_W-1:0] INIT_LAST  = SEQ_W'(INIT_CYCLES - 1);
    localparam logic [SEQ_W-1:0] DRAIN_LAST = SEQ_W'(DRAIN_CYCLES - 1);

    state_e            state_q, state_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              load_use;
    logic              active;
    logic              ev_freeze, ev_branch, ev_lu, ev_halt;
    logic [7:0]        ctl;

    pipe_hazard_det #(.REG_AW(REG_AW)) u_hazard (
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .load_use   (load_use)
    );

    // Prioritised events; only RUN and DRAIN react to datapath hazards.
    assign active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign ev_freeze = active && mem_busy;
    assign ev_branch = active && !mem_busy && mem_pcsrc;
    assign ev_lu     = active && !mem_busy && !mem_pcsrc && load_use;
    assign ev_halt   = (state_q == ST_RUN) && halt_req &&
                       !mem_busy && !mem_pcsrc && !load_use;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        unique case (state_q)
            ST_INIT: begin
                if (seq_q == INIT_LAST) begin
                    state_d = ST_RUN;
                    seq_d   = '0;
                end else begin
                    seq_d = seq_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (ev_halt) begin
                    state_d = ST_DRAIN;
                    seq_d   = '0;
                end
            end
            ST_DRAIN: begin
                // Only cycles where the pipe actually moves retire work;
                // a branch squash still advances.
                if (!ev_freeze && !ev_lu) begin
                    if (seq_q == DRAIN_LAST) begin
                        state_d = ST_HALT;
                        seq_d   = '0;
                    end else begin
                        seq_d = seq_q + 1'b1;
                    end
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_INIT;
                    seq_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                seq_d   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        ctl    = 8'b0;
        halted = 1'b0;
        unique case (state_q)
            ST_INIT: ctl = 8'b0_1111_111;
            ST_RUN: begin
                if (ev_freeze)      ctl = 8'b0_0000_000;
                else if (ev_branch) ctl = 8'b1_1111_111;
                else if (ev_lu)     ctl = 8'b0_0111_010;
                else                ctl = 8'b1_1111_000;
            end
            ST_DRAIN: begin
                // Fetch is stopped; a taken branch still loads the PC so
                // the target survives until resume.
                if (ev_freeze)      ctl = 8'b0_0000_000;
                else if (ev_branch) ctl = 8'b1_1111_111;
                else if (ev_lu)     ctl = 8'b0_0111_110;
                else                ctl = 8'b0_1111_100;
            end
            ST_HALT: begin
                ctl    = 8'b0_0000_000;
                halted = 1'b1;
            end
            default: ctl = 8'b0_1111_111;
        endcase
    end

    assign pc_write     = ctl[OUT_PC_W];
    assign if_id_write  = ctl[OUT_IFID_W];
    assign id_ex_write  = ctl[OUT_IDEX_W];
    assign ex_mem_write = ctl[OUT_EXMEM_W];
    assign mem_wb_write = ctl[OUT_MEMWB_W];
    assign if_id_flush  = ctl[OUT_IFID_F];
    assign id_ex_bubble = ctl[OUT_IDEX_B];
    assign ex_mem_flush = ctl[OUT_EXMEM_F];
    assign state        = state_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((state_q != ST_HALT) && (cyc_q != '1))
                cyc_q <= cyc_q + 1'b1;
            if ((ev_freeze || ev_lu) && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
            if (ev_branch && (flush_q != '1))
                flush_q <= flush_q + 1'b1;
        end
    end

    assign cyc_cnt   = cyc_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign cyc_cnt   = '0;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
